// File: rtl/weight_pattern_pkg.sv
// Shared types and helpers for the weight pattern generator.
// Holds the FSM state encoding and the top-k mask used to detect the final pattern.
package weight_pattern_pkg;

  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // k ones packed into the most significant of `width` bits; the last pattern in ascending order.
  function automatic logic [MAX_WIDTH-1:0] top_k_mask(input int k, input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if ((i < width) && (i >= width - k)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/weight_pattern_gen_bit_weight.sv
// Combinational popcount of a WIDTH-bit word into CW bits.
module bit_weight #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/weight_pattern_gen.sv
// Enumerates every WIDTH-bit pattern with exactly k ones, ascending, on a valid/ready stream.
// Define WEIGHT_PATTERN_INDEX_EN to add the pat_index ordinal output.
module weight_pattern_gen
  import weight_pattern_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CW-1:0]    req_weight,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [WIDTH-1:0] pat_data,
  output logic             pat_last,
  output logic             err,
  output logic             busy
`ifdef WEIGHT_PATTERN_INDEX_EN
  ,
  output logic [WIDTH-1:0] pat_index
`endif
);

  state_t               state_reg;
  logic [WIDTH-1:0]     cand_reg;
  logic [CW-1:0]        k_reg;
  logic [CW-1:0]        cand_weight;
  logic [MAX_WIDTH-1:0] last_mask;

  bit_weight #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_weight (
    .data  (cand_reg),
    .count (cand_weight)
  );

  assign last_mask = top_k_mask(32'(k_reg), WIDTH);
  assign pat_last  = pat_valid & (MAX_WIDTH'(pat_data) == last_mask);
  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cand_reg  <= '0;
      k_reg     <= '0;
      pat_valid <= 1'b0;
      pat_data  <= '0;
      err       <= 1'b0;
`ifdef WEIGHT_PATTERN_INDEX_EN
      pat_index <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (32'(req_weight) > WIDTH) begin
              err <= 1'b1;
            end else begin
              k_reg     <= req_weight;
              cand_reg  <= '0;
              state_reg <= SCAN;
`ifdef WEIGHT_PATTERN_INDEX_EN
              pat_index <= '0;
`endif
            end
          end
        end
        SCAN: begin
          // A match always exists at or below the top-k mask, so cand never wraps.
          if (cand_weight == k_reg) begin
            pat_data  <= cand_reg;
            pat_valid <= 1'b1;
            state_reg <= HOLD;
          end else begin
            cand_reg <= cand_reg + WIDTH'(1);
          end
        end
        HOLD: begin
          if (pat_ready) begin
            pat_valid <= 1'b0;
`ifdef WEIGHT_PATTERN_INDEX_EN
            pat_index <= pat_index + WIDTH'(1);
`endif
            if (pat_last) begin
              state_reg <= IDLE;
            end else begin
              cand_reg  <= pat_data + WIDTH'(1);
              state_reg <= SCAN;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Bench for weight_pattern_gen: directed scenarios plus randomized weights/backpressure
// checked against a popcount-based reference list built from plain arithmetic.
module tb_weight_pattern_gen;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_weight;
  logic          pat_valid;
  logic          pat_ready;
  logic [W-1:0]  pat_data;
  logic          pat_last;
  logic          err;
  logic          busy;
`ifdef WEIGHT_PATTERN_INDEX_EN
  logic [W-1:0]  pat_index;
`endif

  int checks   = 0;
  int failures = 0;

  weight_pattern_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_weight (req_weight),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .pat_last   (pat_last),
    .err        (err),
    .busy       (busy)
`ifdef WEIGHT_PATTERN_INDEX_EN
    ,
    .pat_index  (pat_index)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests weight k and follows the whole sequence; stall_pat holds pat_ready low
  // for 3 cycles on that pattern, poke fires a req_valid pulse while busy.
  task automatic run_seq(input int k, input bit rand_ready, input int stall_pat, input bit poke);
    int exp_q[$];
    int idx, cyc, hs_cyc, prev, stall_left;
    bit seen;
    for (int v = 0; v < (1 << W); v++)
      if ($countones(v) == k) exp_q.push_back(v);
    req_valid  = 1'b1;
    req_weight = k[CW-1:0];
    pat_ready  = 1'b0;
    step();
    req_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_req_ready", req_ready, 0);
    idx = 0; cyc = 0; hs_cyc = 0; prev = -1; seen = 0; stall_left = 3;
    while (idx < exp_q.size() && cyc < 200) begin
      if (poke) begin
        req_valid  = (cyc == 0);
        req_weight = CW'(1);
      end
      pat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pat_valid) begin
        if (!seen) begin
          check("gap_cycles", cyc - hs_cyc, exp_q[idx] - prev);
          seen = 1;
        end
        check("pat_data", pat_data, exp_q[idx]);
        check("pat_last", pat_last, (idx == exp_q.size() - 1));
        check("busy_hold", busy, 1);
`ifdef WEIGHT_PATTERN_INDEX_EN
        check("pat_index", pat_index, idx);
`endif
        if (stall_pat >= 0 && exp_q[idx] == stall_pat && stall_left > 0) begin
          pat_ready = 1'b0;
          stall_left--;
        end
        if (pat_ready) begin
          hs_cyc = cyc + 1;
          prev   = exp_q[idx];
          idx++;
          seen   = 0;
        end
      end
      step();
      cyc++;
    end
    req_valid = 1'b0;
    pat_ready = 1'b0;
    check("seq_timeout", (cyc < 200), 1);
    check("end_pat_valid", pat_valid, 0);
    check("end_busy", busy, 0);
    check("end_req_ready", req_ready, 1);
    check("end_err", err, 0);
    if (stall_pat >= 0) check("stall_used", stall_left, 0);
    $display("seq k=%0d patterns=%0d cycles=%0d", k, idx, cyc);
  endtask

  task automatic bad_req(input int k);
    req_valid  = 1'b1;
    req_weight = k[CW-1:0];
    step();
    req_valid = 1'b0;
    check("err_pulse", err, 1);
    check("err_req_ready", req_ready, 1);
    check("err_busy", busy, 0);
    step();
    check("err_one_cycle", err, 0);
    for (int i = 0; i < 4; i++) begin
      check("err_no_pattern", pat_valid, 0);
      step();
    end
    $display("bad request k=%0d", k);
  endtask

  initial begin
    int wait_cyc;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_weight = '0;
    pat_ready  = 1'b0;
    #3;
    check("rst_pat_valid", pat_valid, 0);
    check("rst_pat_data", pat_data, 0);
    check("rst_pat_last", pat_last, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_seq(2, 0, -1, 0);
    run_seq(0, 0, -1, 0);
    run_seq(4, 0, -1, 0);
    bad_req(5);
    run_seq(1, 0, 2, 0);

    // Reset asserted asynchronously while a k=3 pattern is held.
    req_valid  = 1'b1;
    req_weight = CW'(3);
    step();
    req_valid = 1'b0;
    wait_cyc = 0;
    while (!pat_valid && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    check("mid_reset_reached_hold", pat_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pat_valid", pat_valid, 0);
    check("mid_rst_pat_data", pat_data, 0);
    check("mid_rst_pat_last", pat_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    $display("mid-sequence reset applied");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_seq(3, 0, -1, 1);

    for (int r = 0; r < 6; r++) run_seq(int'($urandom_range(0, W)), 1, -1, 0);
    bad_req(int'($urandom_range(W + 1, (1 << CW) - 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
